// File: rtl/block_transpose_pkg.sv
// Shared types for the block transpose slice: per-bank state and bank index.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package block_transpose_pkg;

  // Life cycle of one storage bank. A bank is written only in EMPTY/FILLING
  // and read only in FULL/DRAINING, so a write and a read never target the
  // same bank in the same cycle.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Two banks (ping-pong), so one bit selects a bank.
  typedef logic bank_idx_t;

  localparam int unsigned NUM_BANKS = 2;

  // Index width for a range of n entries; never returns zero so that
  // degenerate sizes (n == 1) still produce a legal one-bit vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_transpose_bank.sv
// One NUM x DW bit store: row write, per-row valid flags, column read mux.
// Latency: write lands on the clock edge; column read is combinational.
// Backpressure: none here; the parent only writes/reads when a bank state allows it.
//
// Ports:
//   clock, rst         rising-edge clock, synchronous active-high reset (clears row flags)
//   i_wr_en/_row/_dat  write input word i_wr_dat into row i_wr_row
//   i_rd_col           column (input bit position) to read
//   o_rd_dat           bit j = row j bit i_rd_col, forced to 0 for rows not written
module transpose_bank
  import block_transpose_pkg::*;
#(
  parameter int NUM = 8,
  parameter int DW  = 6,
  localparam int RW = idx_w(NUM),
  localparam int CW = idx_w(DW)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [RW-1:0]   i_wr_row,
  input  logic [DW-1:0]   i_wr_dat,
  input  logic [CW-1:0]   i_rd_col,
  output logic [NUM-1:0]  o_rd_dat
);

  logic [DW-1:0]  r_mem [NUM];
  logic [NUM-1:0] r_row_vld;

  // Storage is never cleared: stale rows are hidden by r_row_vld instead.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_dat;
    end
  end

  // Row 0 is always the first write of a block, so writing it wipes the
  // flags left over from the previous block held in this bank.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_row_vld <= '0;
    end else if (i_wr_en) begin
      if (i_wr_row == '0) begin
        r_row_vld <= NUM'(1);
      end else begin
        r_row_vld[i_wr_row] <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_dat = '0;
    for (int j = 0; j < NUM; j++) begin
      o_rd_dat[j] = r_row_vld[j] & r_mem[j][i_rd_col];
    end
  end

endmodule

// File: rtl/block_transpose.sv
// Bit-matrix transpose: up to NUM input words of DW bits -> DW output words of NUM bits.
// Latency: first output word valid the cycle after the closing input accept; 1 word/cycle each side.
// Backpressure: valid/ready both sides; in_ready drops only when both ping-pong banks hold unread blocks.
//
// Ports:
//   clock, rst                   rising-edge clock, synchronous active-high reset
//   rev_mode                     (only with BLOCK_TRANSPOSE_REVERSE_EN) emit a block's words
//                                highest index first; sampled with the block's first word
//   in_data/in_valid/in_ready    input word stream; in_last closes a block early
//   out_data/out_valid/out_ready output word stream; out_last marks a block's final word
//   short_err                    one-cycle pulse after a block closed with fewer than NUM words
//
// Optional feature macro: BLOCK_TRANSPOSE_REVERSE_EN (default build: ascending order, no rev_mode port).
module block_transpose
  import block_transpose_pkg::*;
#(
  parameter int NUM = 8,
  parameter int DW  = 6
) (
  input  logic            clock,
  input  logic            rst,
`ifdef BLOCK_TRANSPOSE_REVERSE_EN
  input  logic            rev_mode,
`endif
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  output logic [NUM-1:0]  out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            short_err
);

  localparam int RW = idx_w(NUM);
  localparam int CW = idx_w(DW);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(DW - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bank_state_e   r_state [NUM_BANKS];
  bank_state_e   w_state_nxt [NUM_BANKS];
  bank_idx_t     r_wr_bank, w_wr_bank_nxt;
  bank_idx_t     r_rd_bank, w_rd_bank_nxt;
  logic [RW-1:0] r_wr_row,  w_wr_row_nxt;
  logic [CW-1:0] r_rd_cnt,  w_rd_cnt_nxt;
  logic          r_short_err, w_short_err_nxt;

  bank_state_e   w_wr_state;
  bank_state_e   w_rd_state;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_in_close;
  logic          w_out_end;
  logic [CW-1:0] w_rd_col;
  logic [NUM-1:0] w_bank_rd [NUM_BANKS];

  assign w_wr_state = r_state[r_wr_bank];
  assign w_rd_state = r_state[r_rd_bank];

  // Handshake outputs are gated by rst so they read idle during reset itself,
  // not just from the cycle after.
  assign in_ready   = !rst && ((w_wr_state == EMPTY) || (w_wr_state == FILLING));
  assign out_valid  = !rst && ((w_rd_state == FULL)  || (w_rd_state == DRAINING));

  assign w_in_fire  = in_valid  && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // A block closes on in_last or when its NUM-th row is written.
  assign w_in_close = in_last || (r_wr_row == ROW_LAST);
  assign w_out_end  = (r_rd_cnt == COL_LAST);

  // ---------------------------------------------------------------------------
  // Per-bank output order
  // ---------------------------------------------------------------------------
`ifdef BLOCK_TRANSPOSE_REVERSE_EN
  logic [NUM_BANKS-1:0] r_rev;

  // Captured with the first word so a block keeps its order even if
  // rev_mode changes while it is being filled or drained.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_rev <= '0;
    end else if (w_in_fire && (w_wr_state == EMPTY)) begin
      r_rev[r_wr_bank] <= rev_mode;
    end
  end

  assign w_rd_col = r_rev[r_rd_bank] ? (COL_LAST - r_rd_cnt) : r_rd_cnt;
`else
  assign w_rd_col = r_rd_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Bank controller: next state
  // ---------------------------------------------------------------------------
  // The write side and the read side each touch only their own bank (they
  // cannot coincide, see the state enum), so both updates may apply in the
  // same cycle -- this is what lets a closing write and a final read overlap
  // without a bubble.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_state_nxt[b] = r_state[b];
    end
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_bank_nxt   = r_rd_bank;
    w_wr_row_nxt    = r_wr_row;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_short_err_nxt = 1'b0;

    if (w_in_fire) begin
      if (w_in_close) begin
        w_state_nxt[r_wr_bank] = FULL;
        w_wr_bank_nxt          = ~r_wr_bank;
        w_wr_row_nxt           = '0;
        w_short_err_nxt        = (r_wr_row != ROW_LAST);
      end else begin
        w_state_nxt[r_wr_bank] = FILLING;
        w_wr_row_nxt           = r_wr_row + RW'(1);
      end
    end

    if (w_out_fire) begin
      if (w_out_end) begin
        w_state_nxt[r_rd_bank] = EMPTY;
        w_rd_bank_nxt          = ~r_rd_bank;
        w_rd_cnt_nxt           = '0;
      end else begin
        w_state_nxt[r_rd_bank] = DRAINING;
        w_rd_cnt_nxt           = r_rd_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= EMPTY;
      end
      r_wr_bank   <= '0;
      r_rd_bank   <= '0;
      r_wr_row    <= '0;
      r_rd_cnt    <= '0;
      r_short_err <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= w_state_nxt[b];
      end
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_wr_row    <= w_wr_row_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_short_err <= w_short_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage banks
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    transpose_bank #(
      .NUM (NUM),
      .DW  (DW)
    ) u_bank (
      .clock    (clock),
      .rst      (rst),
      .i_wr_en  (w_in_fire && (r_wr_bank == bank_idx_t'(g))),
      .i_wr_row (r_wr_row),
      .i_wr_dat (in_data),
      .i_rd_col (w_rd_col),
      .o_rd_dat (w_bank_rd[g])
    );
  end

  assign out_data  = out_valid ? w_bank_rd[r_rd_bank] : '0;
  assign out_last  = out_valid && w_out_end;
  assign short_err = !rst && r_short_err;

endmodule

// File: tb/tb_block_transpose.sv
module tb_block_transpose;

  localparam int NUM = 8;
  localparam int DW  = 6;

  logic           clock = 1'b0;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [NUM-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           short_err;
`ifdef BLOCK_TRANSPOSE_REVERSE_EN
  logic           rev_mode;
`endif

  block_transpose #(.NUM(NUM), .DW(DW)) dut (
    .clock     (clock),
    .rst       (rst),
`ifdef BLOCK_TRANSPOSE_REVERSE_EN
    .rev_mode  (rev_mode),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .short_err (short_err)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [NUM-1:0] dat;
    logic           last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   phase = 0;

  // monitor-owned bookkeeping
  int   short_cnt     = 0;
  int   mon_phase     = -1;
  int   ph_fires      = 0;
  int   ph_gaps_in    = 0;
  int   ph_gaps_all   = 0;
  int   ph_first_last = -1;
  int   last_fire_cyc = 0;
  bit   prev_was_last = 1'b0;

  // Hand-computed vectors: 0=A 1=B 2=C 3=D 4=short block S
  logic [DW-1:0]  blk_in  [5][8];
  logic [NUM-1:0] blk_out [5][6];
  int             blk_len [5];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int b, input bit rev);
    exp_t e;
    int   kk;
    for (int k = 0; k < DW; k++) begin
      kk     = rev ? (DW - 1 - k) : k;
      e.dat  = blk_out[b][kk];
      e.last = (k == DW - 1);
      sb.push_back(e);
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic send_word(input logic [DW-1:0] d, input logic l, output bit stalled);
    int n;
    n        = 0;
    stalled  = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      stalled = 1'b1;
      n++;
      @(negedge clock);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_block(input int b, input bit push, input bit use_last, input bit rev,
                            inout int stalls);
    bit st;
    if (push) push_exp(b, rev);
    for (int j = 0; j < blk_len[b]; j++) begin
      send_word(blk_in[b][j], use_last && (j == blk_len[b] - 1), st);
      if (st) stalls++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Scoreboard monitor: compares every accepted output word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_phase != phase) begin
        mon_phase     = phase;
        ph_fires      = 0;
        ph_gaps_in    = 0;
        ph_gaps_all   = 0;
        ph_first_last = -1;
      end
      if (short_err) short_cnt++;
      if (out_valid && out_ready) begin
        if (ph_fires > 0 && cyc != last_fire_cyc + 1) begin
          ph_gaps_all++;
          if (!prev_was_last) ph_gaps_in++;
        end
        ph_fires++;
        last_fire_cyc = cyc;
        prev_was_last = out_last;
        if (out_last && ph_first_last < 0) ph_first_last = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got data 0x%0h, expected no output", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.dat);
          chk("out_last", out_last, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int rc;
    int n;
    bit st;

    blk_in[0]  = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F, 6'h00};
    blk_out[0] = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h50, 8'h60};
    blk_in[1]  = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    blk_out[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    blk_in[2]  = '{6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15};
    blk_out[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    blk_in[3]  = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00};
    blk_out[3] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    blk_in[4]  = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    blk_out[4] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    blk_len    = '{8, 8, 8, 8, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef BLOCK_TRANSPOSE_REVERSE_EN
    rev_mode  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_short_err", short_err, 0);
    chk("rst_out_data",  out_data,  0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", in_ready,  1);
    chk("idle_out_valid",  out_valid, 0);
    @(posedge clock); #1;

    // Basic block, latency 1
    phase  = 1;
    stalls = 0;
    send_block(0, 1, 1, 0, stalls);
    @(negedge clock);
    chk("latency1_out_valid", out_valid, 1);
    wait_drain();

    // Short block
    phase = 2;
    @(posedge clock); #1;
    send_block(4, 1, 1, 0, stalls);
    @(negedge clock);
    chk("short_err_pulse", short_err, 1);
    @(negedge clock);
    chk("short_err_one_cycle", short_err, 0);
    wait_drain();

    // Continuous stream of 4 blocks (B and D close by count, no in_last)
    phase = 3;
    @(posedge clock); #1;
    stalls = 0;
    send_block(0, 1, 1, 0, stalls);
    send_block(1, 1, 0, 0, stalls);
    send_block(2, 1, 1, 0, stalls);
    send_block(3, 1, 0, 0, stalls);
    chk("stream_no_in_stall", stalls, 0);
    wait_drain();
    chk("stream_out_words",     ph_fires,   24);
    chk("stream_no_block_gaps", ph_gaps_in, 0);

    // Backpressure: both banks full, 17th word held off
    phase     = 4;
    @(posedge clock); #1;
    out_ready = 1'b0;
    stalls    = 0;
    send_block(0, 1, 1, 0, stalls);
    send_block(1, 1, 1, 0, stalls);
    push_exp(2, 0);
    in_valid = 1'b1;
    in_data  = blk_in[2][0];
    in_last  = 1'b0;
    @(negedge clock);
    chk("ready_low_17th", in_ready,  0);
    chk("valid_held",     out_valid, 1);
    repeat (3) @(negedge clock);
    chk("ready_still_low", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    rc = cyc;
    chk("ready_after_out_last", rc, ph_first_last + 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (ph_fires < 12 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("release_words",      ph_fires,    12);
    chk("release_contiguous", ph_gaps_all, 0);
    @(posedge clock); #1;
    for (int j = 1; j < 8; j++) begin
      send_word(blk_in[2][j], j == 7, st);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();

    // Reset in the middle of the second block
    phase     = 5;
    @(posedge clock); #1;
    out_ready = 1'b0;
    send_block(0, 0, 1, 0, stalls);
    for (int j = 0; j < 4; j++) begin
      send_word(blk_in[1][j], 1'b0, st);
    end
    in_data = blk_in[1][4];
    rst     = 1'b1;
    @(negedge clock);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready",  in_ready,  0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready",  in_ready,  1);
    @(posedge clock); #1;
    send_block(4, 1, 1, 0, stalls);
    wait_drain();
    @(posedge clock); #1;
    send_block(3, 1, 0, 0, stalls);
    wait_drain();

`ifdef BLOCK_TRANSPOSE_REVERSE_EN
    // Reverse order block followed by an ascending one
    phase = 6;
    @(posedge clock); #1;
    rev_mode = 1'b1;
    push_exp(0, 1);
    send_block(0, 0, 1, 1, stalls);
    rev_mode = 1'b0;
    send_block(2, 1, 1, 0, stalls);
    wait_drain();
`endif

    chk("short_err_count", short_cnt, 2);
    chk("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
